// File: rtl/mix_fu_pkg.sv
// Shared types for the operand-mixing functional unit: XLEN, trans_id width,
// functional-unit/op enumerators, operand bundle and exception record.
package mix_fu_pkg;

  localparam int XLEN          = 32;
  localparam int TRANS_ID_BITS = 3;

  // Exception cause code for an illegal instruction.
  localparam logic [XLEN-1:0] ILLEGAL_INSTR = XLEN'(2);

  typedef enum logic [3:0] {
    NONE = 4'd0,
    ALU  = 4'd1,
    MIX  = 4'd2
  } fu_t;

  typedef enum logic [3:0] {
    ADD        = 4'd0,
    SUB        = 4'd1,
    MIX_HALF   = 4'd8,
    MIX_PACK   = 4'd9,
    MIX_SWAP   = 4'd10,
    MIX_FUNNEL = 4'd11
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

endpackage

// File: rtl/mix_fu_datapath.sv
// Combinational op decode and compute for mix_fu. Produces the XLEN result
// and an illegal flag for any op this build does not implement.
// MIX_FU_FUNNEL_EN: when defined, MIX_FUNNEL is decoded and the variable
// funnel shifter is built; otherwise MIX_FUNNEL decodes as illegal.
module mix_fu_datapath
  import mix_fu_pkg::*;
#(
  parameter int SHAMT = 16
) (
  input  fu_op            operation,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

`ifdef MIX_FU_FUNNEL_EN
  logic [SW-1:0]   s;
  logic [SW:0]     rs;
  logic [XLEN-1:0] funnel;
  logic            unused_imm;

  assign s          = imm[SW-1:0];
  assign rs         = (SW+1)'(XLEN) - {1'b0, s};
  // s==0 is routed to operand_a so the b shift never reaches XLEN.
  assign funnel     = (s == '0) ? operand_a : ((operand_a >> s) | (operand_b << rs));
  assign unused_imm = ^imm[XLEN-1:SW];
`else
  logic unused_imm;
  assign unused_imm = ^imm;
`endif

  // Decode the op and select the matching re-arrangement.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (operation)
      MIX_HALF: result = (operand_a >> SHAMT) | (operand_b << (XLEN - SHAMT));
      MIX_PACK: result = {operand_b[XLEN/2-1:0], operand_a[XLEN/2-1:0]};
      MIX_SWAP: begin
        for (int i = 0; i < XLEN/8; i++) begin
          result[8*i +: 8] = operand_a[XLEN-8-8*i +: 8];
        end
      end
`ifdef MIX_FU_FUNNEL_EN
      MIX_FUNNEL: result = funnel;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mix_fu.sv
// Pipelined operand-mixing functional unit. Compute happens in stage 0,
// stages 1..LATENCY carry {valid, trans_id, result, exception}; outputs come
// from stage LATENCY. Flush clears every stage and masks the output valid.
// Optional funnel shift op is enabled by defining MIX_FU_FUNNEL_EN.
module mix_fu
  import mix_fu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int SHAMT   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     mix_valid_i,
  input  fu_data_t                 fu_data_i,
  output logic                     mix_ready_o,
  output logic                     mix_valid_o,
  output logic [XLEN-1:0]          mix_result_o,
  output logic [TRANS_ID_BITS-1:0] mix_trans_id_o,
  output exception_t               mix_exception_o
);

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               exception;
  } mix_stage_t;

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("mix_fu: LATENCY must be 1..3");
  end
  if (SHAMT < 1 || SHAMT > XLEN-1) begin : g_bad_shamt
    $error("mix_fu: SHAMT must be 1..XLEN-1");
  end

  logic [XLEN-1:0] dp_result;
  logic            dp_illegal;
  logic            unused_fu;
  mix_stage_t      stg_p0;
  mix_stage_t      stg_in [1:LATENCY];
  mix_stage_t      stg_q  [1:LATENCY];

  assign unused_fu = ^fu_data_i.fu;

  mix_fu_datapath #(.SHAMT(SHAMT)) u_datapath (
    .operation (fu_data_i.operation),
    .operand_a (fu_data_i.operand_a),
    .operand_b (fu_data_i.operand_b),
    .imm       (fu_data_i.imm),
    .result    (dp_result),
    .illegal   (dp_illegal)
  );

  // ---- stage 0: accept, compute, form the exception record ----
  always_comb begin
    stg_p0           = '0;
    stg_p0.valid     = mix_valid_i & ~flush_i;
    stg_p0.trans_id  = fu_data_i.trans_id;
    stg_p0.result    = dp_illegal ? '0 : dp_result;
    if (dp_illegal) begin
      stg_p0.exception.valid = 1'b1;
      stg_p0.exception.cause = ILLEGAL_INSTR;
    end
  end

  // Feed of each registered stage: stage 0 for the first, predecessor otherwise.
  always_comb begin
    stg_in[1] = stg_p0;
    for (int i = 2; i <= LATENCY; i++) begin
      stg_in[i] = stg_q[i-1];
    end
  end

  // ---- stages 1..LATENCY: valid cleared by flush, payload loads only for live slots ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i <= LATENCY; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= LATENCY; i++) begin
        stg_q[i].valid <= stg_in[i].valid & ~flush_i;
        if (stg_in[i].valid & ~flush_i) begin
          stg_q[i].trans_id  <= stg_in[i].trans_id;
          stg_q[i].result    <= stg_in[i].result;
          stg_q[i].exception <= stg_in[i].exception;
        end
      end
    end
  end

  assign mix_ready_o     = rst_ni;
  assign mix_valid_o     = stg_q[LATENCY].valid & ~flush_i;
  assign mix_result_o    = stg_q[LATENCY].result;
  assign mix_trans_id_o  = stg_q[LATENCY].trans_id;
  assign mix_exception_o = stg_q[LATENCY].exception;

endmodule
